// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type and I2C protocol constants
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;
    localparam logic       RW_WRITE      = 1'b0;
    localparam logic       RW_READ       = 1'b1;
    localparam logic [6:0] GENERAL_CALL  = 7'h00;
    localparam int         BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronise one bus line, reject short pulses, emit edge strobes
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_f,
    output logic rise,
    output logic fall
);
    localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;
    assign differ = sync[1] != line_f;
    assign accept = differ && cnt == CW'(FILTER_LEN - 1);
    // Two-flop synchroniser, then accept a new level only after FILTER_LEN matching samples; idle bus is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= 2'b11;
            cnt    <= '0;
            line_f <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[0], line_i};
            cnt    <= (differ && !accept) ? cnt + 1'b1 : '0;
            line_f <= accept ? sync[1] : line_f;
            rise   <= accept && sync[1];
            fall   <= accept && !sync[1];
        end
    end
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampled I2C target fronting a byte register file with an auto-incrementing pointer
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              start_det,
    output logic              stop_det
);
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              oe_d, busy_d, wr_en_d;
    logic [REG_AW-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              scl_f, scl_rise, scl_fall;
    logic              sda_f, sda_rise, sda_fall;
    logic              start, stop, byte_done, addr_hit;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst(rst), .line_i(scl_i), .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst(rst), .line_i(sda_i), .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    assign start     = sda_fall && scl_f;
    assign stop      = sda_rise && scl_f;
    assign byte_done = cnt_q == 4'(BITS_PER_BYTE);
    assign addr_hit  = sr_q[7:1] == addr && sr_q[7:1] != GENERAL_CALL;
    assign rd_addr   = ptr_q;

    // Next-state and datapath: bus conditions override everything, bytes are shifted on scl_rise, SDA moves on scl_fall
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        oe_d      = sda_oe;
        busy_d    = busy;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && !byte_done) begin
                        sr_d  = {sr_q[6:0], sda_f};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        cnt_d = '0;
                        oe_d  = 1'b1;
                        if (state_q == ADDR) begin
                            state_d = addr_hit ? ADDR_ACK : IGNORE;
                            oe_d    = addr_hit;
                            busy_d  = busy || addr_hit;
                            rw_d    = sr_q[0];
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = sr_q[REG_AW-1:0];
                        end else begin
                            state_d   = WDATA_ACK;
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sr_q;
                            ptr_d     = ptr_q + 1'b1;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                        state_d = state_q == ADDR_ACK ? PTR : WDATA;
                        if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                            state_d = RDATA;
                            sr_d    = rd_data;
                            oe_d    = !rd_data[7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            state_d = RDATA_ACK;
                            cnt_d   = '0;
                            oe_d    = 1'b0;
                        end else begin
                            sr_d  = {sr_q[6:0], 1'b0};
                            oe_d  = !sr_q[6];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        state_d = sda_f ? IGNORE : RDATA_ACK;
                        ptr_d   = sda_f ? ptr_q : ptr_q + 1'b1;
                        cnt_d   = sda_f ? cnt_q : 4'd1;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        state_d = RDATA;
                        cnt_d   = '0;
                        sr_d    = rd_data;
                        oe_d    = !rd_data[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe    <= oe_d;
            busy      <= busy_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            start_det <= start;
            stop_det  <= stop;
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-level I2C master against a register-file model with a write scoreboard
module tb_i2c_slave_regfile;
    localparam int Q = 12;
    typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] addr = 7'h2A;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_en, busy, start_det, stop_det;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic [7:0] regs [16];
    logic [7:0] mdl [16];
    logic [3:0] mptr;
    logic [7:0] wq [$];
    wr_t        sb [$];
    wr_t        e;
    int total = 0, bad = 0, n_start = 0, n_stop = 0;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = regs[rd_addr];

    i2c_slave_regfile dut (
        .clk(clk), .rst(rst), .addr(addr), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .start_det(start_det), .stop_det(stop_det)
    );

    always @(posedge clk) begin
        if (!rst) regs <= mdl;
        else if (wr_en) regs[wr_addr] <= wr_data;
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (wr_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected got=%0d/%0d required=none", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.a));
                chk("wr_data", int'(wr_data), int'(e.d));
            end
        end
    end

    task automatic hold(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic bus_start();
        sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b0; hold(Q); scl_m = 1'b0; hold(Q);
    endtask
    task automatic bus_stop();
        sda_m = 1'b0; hold(Q); scl_m = 1'b1; hold(Q); sda_m = 1'b1; hold(Q);
    endtask
    task automatic put_bit(logic b);
        sda_m = b; hold(Q); scl_m = 1'b1; hold(2 * Q); scl_m = 1'b0; hold(Q);
    endtask
    task automatic get_bit(output logic b);
        sda_m = 1'b1; hold(Q); scl_m = 1'b1; hold(Q); b = sda_bus; hold(Q); scl_m = 1'b0; hold(Q);
    endtask
    task automatic put_byte(logic [7:0] v, logic want_ack, string nm);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(a);
        chk(nm, int'(a), want_ack ? 0 : 1);
    endtask
    task automatic get_byte(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) get_bit(v[i]);
        put_bit(!ack);
    endtask

    task automatic do_write(logic [7:0] p);
        int s0 = n_start, t0 = n_stop;
        logic [3:0] a;
        bus_start();
        put_byte({addr, 1'b0}, 1'b1, "ack_addr_w");
        put_byte(p, 1'b1, "ack_ptr");
        a = p[3:0];
        while (wq.size() > 0) begin
            logic [7:0] d = wq.pop_front();
            sb.push_back('{a: a, d: d});
            mdl[a] = d;
            a = a + 4'd1;
            put_byte(d, 1'b1, "ack_wdata");
        end
        mptr = a;
        chk("busy_in_write", int'(busy), 1);
        bus_stop();
        hold(10);
        chk("busy_after_stop", int'(busy), 0);
        chk("ptr_after_write", int'(rd_addr), int'(mptr));
        chk("start_cnt_w", n_start - s0, 1);
        chk("stop_cnt_w", n_stop - t0, 1);
    endtask

    task automatic do_read(int n, logic set_ptr, logic [7:0] p);
        logic [7:0] v;
        bus_start();
        if (set_ptr) begin
            put_byte({addr, 1'b0}, 1'b1, "ack_addr_w");
            put_byte(p, 1'b1, "ack_ptr");
            mptr = p[3:0];
            bus_start();
        end
        put_byte({addr, 1'b1}, 1'b1, "ack_addr_r");
        for (int i = 0; i < n; i++) begin
            get_byte(v, i != n - 1);
            chk("rd_byte", int'(v), int'(mdl[mptr]));
            if (i != n - 1) mptr = mptr + 4'd1;
        end
        hold(Q);
        chk("oe_after_nack", int'(sda_oe), 0);
        chk("busy_after_nack", int'(busy), 1);
        bus_stop();
        hold(10);
        chk("busy_after_rstop", int'(busy), 0);
        chk("ptr_after_read", int'(rd_addr), int'(mptr));
    endtask

    initial begin
        int s0, t0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'($urandom);
        mptr = 4'd0;
        hold(5);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_start_det", int'(start_det), 0);
        rst = 1'b1;
        hold(10);
        wq = '{8'h11, 8'h22, 8'h33};
        do_write(8'h03);
        wq = '{8'hAA, 8'hBB};
        do_write(8'h0F);
        mdl[5] = 8'h5A;
        mdl[6] = 8'hC3;
        wq = '{8'h5A, 8'hC3};
        do_write(8'h05);
        do_read(2, 1'b1, 8'h05);
        do_read(1, 1'b0, 8'h00);
        s0 = n_start;
        bus_start();
        put_byte(8'h60, 1'b0, "nack_mismatch");
        put_byte(8'h03, 1'b0, "nack_ignored");
        chk("busy_mismatch", int'(busy), 0);
        bus_stop();
        bus_start();
        put_byte(8'h00, 1'b0, "nack_gcall");
        put_byte(8'h11, 1'b0, "nack_gcall_data");
        chk("busy_gcall", int'(busy), 0);
        bus_stop();
        hold(10);
        chk("start_cnt_mismatch", n_start - s0, 2);
        s0 = n_start;
        t0 = n_stop;
        sda_m = 1'b0; hold(2); sda_m = 1'b1; hold(20);
        chk("glitch2_start", n_start - s0, 0);
        sda_m = 1'b0; hold(3); sda_m = 1'b1; hold(20);
        chk("glitch3_start", n_start - s0, 1);
        chk("glitch3_stop", n_stop - t0, 1);
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            do_write(8'($urandom));
            do_read($urandom_range(1, 4), 1'($urandom), 8'($urandom));
        end
        wq = '{8'h00};
        do_write(8'h09);
        bus_start();
        put_byte({addr, 1'b0}, 1'b1, "ack_addr_w");
        put_byte(8'h09, 1'b1, "ack_ptr");
        bus_start();
        put_byte({addr, 1'b1}, 1'b1, "ack_addr_r");
        hold(2);
        chk("oe_drive0", int'(sda_oe), 1);
        rst = 1'b0;
        #1;
        chk("rst_async_oe", int'(sda_oe), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_ptr", int'(rd_addr), 0);
        mptr = 4'd0;
        hold(3);
        rst = 1'b1;
        hold(10);
        bus_stop();
        hold(10);
        do_read(1, 1'b0, 8'h00);
        hold(50);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
